// File: rtl/match_select.sv
// match_select: SSD cost formation and serial minimum search over the 64
// g-window candidates produced by the parallel f/g window calculator.
// Optional feature: define MATCH_SELECT_UNIQUE_EN to track the second-best
// cost and drive the uniq output (best-to-second gap >= UNIQ_MARGIN).
module match_select #(
   parameter int unsigned NUNIT = 16,
   parameter int unsigned NBEAT = 4,
   parameter int unsigned SUMW  = 14,
   parameter int unsigned COSTW = 16
`ifdef MATCH_SELECT_UNIQUE_EN
   ,parameter int unsigned UNIQ_MARGIN = 8
`endif
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    finalstart,
   input  logic                    valid,
   input  logic [SUMW-1:0]         f2sum,
   input  logic [NUNIT*SUMW-1:0]   fg_bus,
   input  logic [NUNIT*SUMW-1:0]   g2_bus,
   output logic                    busy,
   output logic                    done,
   output logic [5:0]              disp,
   output logic [COSTW-1:0]        min_cost,
   output logic                    overrun
`ifdef MATCH_SELECT_UNIQUE_EN
   ,output logic                   uniq
`endif
);

   localparam int unsigned NCAND = NUNIT * NBEAT;
   localparam int unsigned IDXW  = $clog2(NCAND);
   localparam int unsigned BEATW = $clog2(NBEAT);
   localparam int unsigned UNITW = $clog2(NUNIT);

   typedef enum logic [1:0] {StIdle, StCollect, StScan, StDone} state_e;

   state_e            state_q, state_d;
   logic [BEATW-1:0]  beat_q, beat_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              wr_en;
   logic [BEATW-1:0]  wr_beat;
   logic              abort;
   logic [COSTW-1:0]  cost_mem [NCAND];
   logic [COSTW-1:0]  beat_cost [NUNIT];
   logic [COSTW-1:0]  cand;
   logic [COSTW-1:0]  best_q;
   logic [IDXW-1:0]   best_idx_q;
`ifdef MATCH_SELECT_UNIQUE_EN
   logic [COSTW-1:0]  second_q;
`endif

   // Per-unit SSD cost f2 + g2 - 2fg in COSTW+1 signed bits, clamped at zero
   for (genvar u = 0; u < NUNIT; u++) begin : g_cost
      logic signed [COSTW:0] diff;
      assign diff = $signed({{(COSTW+1-SUMW){1'b0}}, f2sum})
                  + $signed({{(COSTW+1-SUMW){1'b0}}, g2_bus[u*SUMW +: SUMW]})
                  - $signed({{(COSTW-SUMW){1'b0}}, fg_bus[u*SUMW +: SUMW], 1'b0});
      assign beat_cost[u] = diff[COSTW] ? '0 : diff[COSTW-1:0];
   end

   assign cand = cost_mem[idx_q];
   assign busy = (state_q == StCollect) || (state_q == StScan);

   // Next state, beat/scan counters and cost memory write control
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      idx_d   = idx_q;
      wr_en   = 1'b0;
      wr_beat = beat_q;
      abort   = 1'b0;
      if (finalstart) begin
         // finalstart wins from any state; a coincident beat becomes beat 0
         state_d = StCollect;
         wr_en   = valid;
         wr_beat = '0;
         beat_d  = valid ? BEATW'(1) : '0;
         abort   = (state_q == StScan);
      end else begin
         unique case (state_q)
            StIdle: begin
            end
            StCollect: begin
               if (valid) begin
                  wr_en  = 1'b1;
                  beat_d = beat_q + 1'b1;
                  if (beat_q == BEATW'(NBEAT-1)) begin
                     state_d = StScan;
                     beat_d  = '0;
                     idx_d   = '0;
                  end
               end
            end
            StScan: begin
               idx_d = idx_q + 1'b1;
               if (idx_q == IDXW'(NCAND-1)) state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   // FSM state and counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         beat_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         idx_q   <= idx_d;
      end
   end

   // Cost memory: one beat of NUNIT costs written in parallel, candidate b*NUNIT+u
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int u = 0; u < NUNIT; u++) begin
            cost_mem[{wr_beat, UNITW'(u)}] <= beat_cost[u];
         end
      end
   end

   // Serial minimum search; strict compare keeps the lowest index on ties
   always_ff @(posedge clk) begin
      if (rst) begin
         best_q     <= '0;
         best_idx_q <= '0;
`ifdef MATCH_SELECT_UNIQUE_EN
         second_q   <= '1;
`endif
      end else if (state_q == StScan) begin
         if (idx_q == '0) begin
            best_q     <= cand;
            best_idx_q <= '0;
`ifdef MATCH_SELECT_UNIQUE_EN
            second_q   <= '1;
`endif
         end else if (cand < best_q) begin
            best_q     <= cand;
            best_idx_q <= idx_q;
`ifdef MATCH_SELECT_UNIQUE_EN
            second_q   <= best_q;
`endif
         end
`ifdef MATCH_SELECT_UNIQUE_EN
         // a cost equal to best is a valid second-best
         else if (cand < second_q) begin
            second_q <= cand;
         end
`endif
      end
   end

   // Registered result, done pulse and sticky overrun flag
   always_ff @(posedge clk) begin
      if (rst) begin
         done     <= 1'b0;
         disp     <= '0;
         min_cost <= '0;
         overrun  <= 1'b0;
`ifdef MATCH_SELECT_UNIQUE_EN
         uniq     <= 1'b0;
`endif
      end else begin
         done <= (state_q == StDone);
         if (state_q == StDone) begin
            disp     <= best_idx_q;
            min_cost <= best_q;
`ifdef MATCH_SELECT_UNIQUE_EN
            uniq     <= (second_q - best_q) >= COSTW'(UNIQ_MARGIN);
`endif
         end
         if (abort) overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_match_select.sv
// Scoreboard bench for match_select: window stimulus pushes the expected
// winner (from a reference cost model) and the done monitor pops/compares.
module tb_match_select;

   localparam int NUNIT = 16;
   localparam int NBEAT = 4;
   localparam int SUMW  = 14;
   localparam int COSTW = 16;
   localparam int NCAND = NUNIT * NBEAT;

   logic                  clk;
   logic                  rst;
   logic                  finalstart;
   logic                  valid;
   logic [SUMW-1:0]       f2sum;
   logic [NUNIT*SUMW-1:0] fg_bus;
   logic [NUNIT*SUMW-1:0] g2_bus;
   logic                  busy;
   logic                  done;
   logic [5:0]            disp;
   logic [COSTW-1:0]      min_cost;
   logic                  overrun;
`ifdef MATCH_SELECT_UNIQUE_EN
   logic                  uniq;
`endif

   typedef struct {
      logic [5:0]       disp;
      logic [COSTW-1:0] cost;
      logic             uniq;
      int               due;
   } exp_t;

   exp_t sb[$];
   exp_t last_exp;
   exp_t mon_e;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   beat_cyc = 0;

   logic [SUMW-1:0] f2_m;
   logic [SUMW-1:0] fg_m [NCAND];
   logic [SUMW-1:0] g2_m [NCAND];

   match_select dut (
      .clk        (clk),
      .rst        (rst),
      .finalstart (finalstart),
      .valid      (valid),
      .f2sum      (f2sum),
      .fg_bus     (fg_bus),
      .g2_bus     (g2_bus),
      .busy       (busy),
      .done       (done),
      .disp       (disp),
      .min_cost   (min_cost),
      .overrun    (overrun)
`ifdef MATCH_SELECT_UNIQUE_EN
      ,.uniq      (uniq)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: costs from the stimulus arrays, first strict minimum,
   // second-best as the minimum over every other candidate
   function automatic exp_t model(input int due);
      exp_t e;
      int   c [NCAND];
      int   best;
      int   bidx;
      int   second;
      for (int i = 0; i < NCAND; i++) begin
         c[i] = int'(f2_m) + int'(g2_m[i]) - 2 * int'(fg_m[i]);
         if (c[i] < 0) c[i] = 0;
      end
      best = c[0];
      bidx = 0;
      for (int i = 1; i < NCAND; i++) begin
         if (c[i] < best) begin
            best = c[i];
            bidx = i;
         end
      end
      second = 65535;
      for (int i = 0; i < NCAND; i++) begin
         if (i != bidx && c[i] < second) second = c[i];
      end
      e.disp = 6'(bidx);
      e.cost = 16'(best);
      e.uniq = (second - best) >= 8;
      e.due  = due;
      return e;
   endfunction

   // Done monitor: every done must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL done_unexpected: done=1 at cycle %0d, required no done", cyc);
         end else begin
            mon_e = sb.pop_front();
            n_vec++;
            if (disp !== mon_e.disp) begin
               n_err++;
               $display("FAIL disp: got %0d, required %0d", disp, mon_e.disp);
            end
            n_vec++;
            if (min_cost !== mon_e.cost) begin
               n_err++;
               $display("FAIL min_cost: got %0d, required %0d", min_cost, mon_e.cost);
            end
            n_vec++;
            if (cyc !== mon_e.due) begin
               n_err++;
               $display("FAIL done_latency: done at cycle %0d, required cycle %0d", cyc, mon_e.due);
            end
`ifdef MATCH_SELECT_UNIQUE_EN
            n_vec++;
            if (uniq !== mon_e.uniq) begin
               n_err++;
               $display("FAIL uniq: got %0b, required %0b", uniq, mon_e.uniq);
            end
`endif
         end
      end
   end

   task automatic fill(input int f2, input int fgv, input int g2v);
      f2_m = SUMW'(f2);
      for (int i = 0; i < NCAND; i++) begin
         fg_m[i] = SUMW'(fgv);
         g2_m[i] = SUMW'(g2v);
      end
   endtask

   task automatic set_cand(input int c, input int fgv, input int g2v);
      fg_m[c] = SUMW'(fgv);
      g2_m[c] = SUMW'(g2v);
   endtask

   task automatic pulse_start();
      finalstart = 1'b1;
      @(negedge clk);
      finalstart = 1'b0;
   endtask

   task automatic send_beat(input int b);
      valid = 1'b1;
      f2sum = f2_m;
      for (int u = 0; u < NUNIT; u++) begin
         fg_bus[u*SUMW +: SUMW] = fg_m[b*NUNIT + u];
         g2_bus[u*SUMW +: SUMW] = g2_m[b*NUNIT + u];
      end
      beat_cyc = cyc;
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic send_window(input bit push);
      pulse_start();
      for (int b = 0; b < NBEAT; b++) send_beat(b);
      if (push) begin
         last_exp = model(beat_cyc + 66);
         sb.push_back(last_exp);
      end
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL %s_timeout: %0d results outstanding after %0d cycles, required 0",
                  name, sb.size(), n);
         sb.delete();
      end
   endtask

   task automatic test_reset();
      int busy_cycles = 0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({busy, done, overrun} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_flags: busy/done/overrun=%03b, required 000", {busy, done, overrun});
      end
      n_vec++;
      if (disp !== 6'd0 || min_cost !== 16'd0) begin
         n_err++;
         $display("FAIL reset_result: disp=%0d min_cost=%0d, required 0 0", disp, min_cost);
      end
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         valid  = 1'b1;
         f2sum  = SUMW'($urandom);
         fg_bus = {NUNIT{SUMW'($urandom)}};
         g2_bus = {NUNIT{SUMW'($urandom)}};
         @(negedge clk);
         if (busy) busy_cycles++;
         valid = 1'b0;
         @(negedge clk);
         if (busy) busy_cycles++;
      end
      repeat (80) begin
         @(negedge clk);
         if (busy) busy_cycles++;
      end
      n_vec++;
      if (busy_cycles !== 0) begin
         n_err++;
         $display("FAIL idle_busy: busy high %0d cycles, required 0", busy_cycles);
      end
      n_vec++;
      if (disp !== 6'd0 || min_cost !== 16'd0) begin
         n_err++;
         $display("FAIL idle_result: disp=%0d min_cost=%0d, required 0 0", disp, min_cost);
      end
   endtask

   task automatic test_single_min();
      fill(100, 0, 50);
      set_cand(37, 40, 10);
      send_window(1'b1);
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL scan_busy: busy=%0b, required 1", busy);
      end
      wait_drain("single_min");
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL post_done_busy: busy=%0b, required 0", busy);
      end
   endtask

   task automatic test_tie_clamp();
      fill(0, 0, 200);
      set_cand(3, 10, 1);
      set_cand(60, 0, 0);
      send_window(1'b1);
      wait_drain("tie_clamp");
   endtask

   task automatic test_restart();
      // partial window holds a deeper minimum that must not survive the restart
      fill(50, 0, 60);
      set_cand(5, 30, 0);
      pulse_start();
      send_beat(0);
      send_beat(1);
      fill(50, 0, 60);
      set_cand(63, 20, 0);
      send_window(1'b1);
      wait_drain("restart");
      repeat (10) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int due;
      fill(300, 100, 20);
      set_cand(17, 150, 20);
      send_window(1'b1);
      due = last_exp.due;
      while (cyc < due - 1) @(negedge clk);
      fill(40, 0, 70);
      set_cand(48, 30, 5);
      set_cand(49, 30, 5);
      pulse_start();
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL done_restart_busy: busy=%0b, required 1", busy);
      end
      for (int b = 0; b < NBEAT; b++) send_beat(b);
      last_exp = model(beat_cyc + 66);
      sb.push_back(last_exp);
      wait_drain("back_to_back");
   endtask

   task automatic test_uniq();
      fill(0, 0, 100);
      set_cand(7, 0, 20);
      set_cand(40, 0, 25);
      send_window(1'b1);
      wait_drain("uniq_gap5");
      fill(0, 0, 100);
      set_cand(7, 0, 20);
      set_cand(40, 0, 28);
      send_window(1'b1);
      wait_drain("uniq_gap8");
      fill(0, 0, 100);
      set_cand(12, 0, 20);
      set_cand(50, 0, 20);
      send_window(1'b1);
      wait_drain("uniq_tie");
   endtask

   task automatic test_overrun();
      exp_t prev;
      prev = last_exp;
      fill(10, 0, 10);
      set_cand(9, 5, 2);
      send_window(1'b1);
      repeat (10) @(negedge clk);
      n_vec++;
      if (overrun !== 1'b0) begin
         n_err++;
         $display("FAIL overrun_pre: overrun=%0b, required 0", overrun);
      end
      // aborted window produces no result
      void'(sb.pop_back());
      fill(90, 10, 30);
      set_cand(22, 50, 10);
      pulse_start();
      n_vec++;
      if (overrun !== 1'b1) begin
         n_err++;
         $display("FAIL overrun_set: overrun=%0b, required 1", overrun);
      end
      n_vec++;
      if (disp !== prev.disp || min_cost !== prev.cost) begin
         n_err++;
         $display("FAIL abort_hold: disp=%0d min_cost=%0d, required %0d %0d",
                  disp, min_cost, prev.disp, prev.cost);
      end
      for (int b = 0; b < NBEAT; b++) send_beat(b);
      last_exp = model(beat_cyc + 66);
      sb.push_back(last_exp);
      wait_drain("overrun");
      n_vec++;
      if (overrun !== 1'b1) begin
         n_err++;
         $display("FAIL overrun_sticky: overrun=%0b, required 1", overrun);
      end
   endtask

   initial begin
      rst        = 1'b1;
      finalstart = 1'b0;
      valid      = 1'b0;
      f2sum      = '0;
      fg_bus     = '0;
      g2_bus     = '0;
      @(negedge clk);
      test_reset();
      test_single_min();
      test_tie_clamp();
      test_restart();
      test_back_to_back();
      test_uniq();
      test_overrun();
      repeat (20) @(negedge clk);
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL leftover: %0d results outstanding, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
